cap_derive: RTL and testbench

CAP_DERIVE -- requirements
Module: cap_derive

---
 rtl/cap_derive.sv | 151 +++++++++++++++
 tb/tb_cap_derive.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cap_derive.sv
// cap_derive: derives a child capability (bounds + permissions) from a parent capability.
// Optional macro CAP_DERIVE_CAUSE_EN adds a registered 3-bit fault cause output.
module cap_derive #(
    parameter int unsigned PERM_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              p_tag,
    input  logic [31:0]       p_base,
    input  logic [31:0]       p_length,
    input  logic [PERM_W-1:0] p_perms,
    input  logic [31:0]       new_base,
    input  logic [31:0]       new_length,
    input  logic [PERM_W-1:0] perm_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              c_tag,
    output logic [31:0]       c_base,
    output logic [31:0]       c_length,
    output logic [PERM_W-1:0] c_perms
`ifdef CAP_DERIVE_CAUSE_EN
    ,
    output logic [2:0]        cause
`endif
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TOP_W   = ADDR_W + 1;
    localparam int unsigned CAUSE_W = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_OK       = 3'b000;
    localparam logic [CAUSE_W-1:0] CAUSE_UNTAGGED = 3'b001;
    localparam logic [CAUSE_W-1:0] CAUSE_BELOW    = 3'b010;
    localparam logic [CAUSE_W-1:0] CAUSE_ABOVE    = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              q_p_tag;
    logic [ADDR_W-1:0] q_p_base;
    logic [ADDR_W-1:0] q_p_length;
    logic [PERM_W-1:0] q_p_perms;
    logic [ADDR_W-1:0] q_new_base;
    logic [ADDR_W-1:0] q_new_length;
    logic [PERM_W-1:0] q_perm_mask;

    logic              accept_c;
    logic              handshake_c;
    logic [TOP_W-1:0]  ptop_c;
    logic [TOP_W-1:0]  ntop_c;
    logic              untagged_c;
    logic              below_c;
    logic              above_c;
    logic              ok_c;

    assign accept_c    = req_valid && req_ready;
    assign handshake_c = rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = CHECK;
            CHECK:   state_next = RESP;
            RESP:    if (handshake_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request snapshot; later input changes are ignored until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p_tag      <= 1'b0;
            q_p_base     <= '0;
            q_p_length   <= '0;
            q_p_perms    <= '0;
            q_new_base   <= '0;
            q_new_length <= '0;
            q_perm_mask  <= '0;
        end else if (accept_c) begin
            q_p_tag      <= p_tag;
            q_p_base     <= p_base;
            q_p_length   <= p_length;
            q_p_perms    <= p_perms;
            q_new_base   <= new_base;
            q_new_length <= new_length;
            q_perm_mask  <= perm_mask;
        end
    end

    // Tops carry one extra bit so a region ending at 2^32 does not wrap
    assign ptop_c     = TOP_W'(q_p_base) + TOP_W'(q_p_length);
    assign ntop_c     = TOP_W'(q_new_base) + TOP_W'(q_new_length);
    assign untagged_c = !q_p_tag;
    assign below_c    = q_new_base < q_p_base;
    assign above_c    = ntop_c > ptop_c;
    assign ok_c       = !(untagged_c || below_c || above_c);

    // Verdict lands on entering RESP; rsp_valid follows one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            c_tag     <= 1'b0;
            c_base    <= '0;
            c_length  <= '0;
            c_perms   <= '0;
        end else begin
            req_ready <= (state_next == IDLE);
            rsp_valid <= (state == RESP) && !handshake_c;
            if (state == CHECK) begin
                c_tag    <= ok_c;
                c_base   <= q_new_base;
                c_length <= q_new_length;
                c_perms  <= ok_c ? (q_p_perms & q_perm_mask) : '0;
            end
        end
    end

`ifdef CAP_DERIVE_CAUSE_EN
    // Fault code, priority untagged > below base > above top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause <= CAUSE_OK;
        end else if (state == CHECK) begin
            if (untagged_c)   cause <= CAUSE_UNTAGGED;
            else if (below_c) cause <= CAUSE_BELOW;
            else if (above_c) cause <= CAUSE_ABOVE;
            else              cause <= CAUSE_OK;
        end
    end
`endif

endmodule

// File: tb/tb_cap_derive.sv
// Directed self-checking bench for cap_derive with an expected-result scoreboard queue.
module tb_cap_derive;

    localparam int unsigned PERM_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              p_tag;
    logic [31:0]       p_base;
    logic [31:0]       p_length;
    logic [PERM_W-1:0] p_perms;
    logic [31:0]       new_base;
    logic [31:0]       new_length;
    logic [PERM_W-1:0] perm_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              c_tag;
    logic [31:0]       c_base;
    logic [31:0]       c_length;
    logic [PERM_W-1:0] c_perms;
`ifdef CAP_DERIVE_CAUSE_EN
    logic [2:0]        cause;
`endif

    cap_derive #(.PERM_W(PERM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .p_tag      (p_tag),
        .p_base     (p_base),
        .p_length   (p_length),
        .p_perms    (p_perms),
        .new_base   (new_base),
        .new_length (new_length),
        .perm_mask  (perm_mask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .c_tag      (c_tag),
        .c_base     (c_base),
        .c_length   (c_length),
        .c_perms    (c_perms)
`ifdef CAP_DERIVE_CAUSE_EN
        ,
        .cause      (cause)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              tag;
        logic [31:0]       base;
        logic [31:0]       length;
        logic [PERM_W-1:0] perms;
        logic [2:0]        cause;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model using 64-bit arithmetic for the tops
    function automatic exp_t model(input logic pt, input logic [31:0] pb, input logic [31:0] pl,
                                   input logic [PERM_W-1:0] pp, input logic [31:0] nb,
                                   input logic [31:0] nl, input logic [PERM_W-1:0] m);
        exp_t e;
        longint unsigned ptop;
        longint unsigned ntop;
        ptop = 64'(pb) + 64'(pl);
        ntop = 64'(nb) + 64'(nl);
        e.base   = nb;
        e.length = nl;
        if (pt == 1'b0)       e.cause = 3'b001;
        else if (nb < pb)     e.cause = 3'b010;
        else if (ntop > ptop) e.cause = 3'b011;
        else                  e.cause = 3'b000;
        e.tag   = (e.cause == 3'b000);
        e.perms = e.tag ? (pp & m) : '0;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".c_tag"}, 64'(c_tag), 64'(e.tag));
        chk({tag, ".c_base"}, 64'(c_base), 64'(e.base));
        chk({tag, ".c_length"}, 64'(c_length), 64'(e.length));
        chk({tag, ".c_perms"}, 64'(c_perms), 64'(e.perms));
`ifdef CAP_DERIVE_CAUSE_EN
        chk({tag, ".cause"}, 64'(cause), 64'(e.cause));
`endif
    endtask

    // Issue one request, scramble inputs after accept, then check the response
    task automatic do_req(input string tag, input logic pt, input logic [31:0] pb,
                          input logic [31:0] pl, input logic [PERM_W-1:0] pp,
                          input logic [31:0] nb, input logic [31:0] nl,
                          input logic [PERM_W-1:0] m, input int hold);
        int   w;
        exp_t e;
        p_tag = pt; p_base = pb; p_length = pl; p_perms = pp;
        new_base = nb; new_length = nl; perm_mask = m;
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) chk({tag, ".accept_timeout"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        sb.push_back(model(pt, pb, pl, pp, nb, nl, m));
        req_valid = 1'b0;
        p_tag = ~pt; p_base = $urandom; p_length = $urandom; p_perms = PERM_W'($urandom);
        new_base = $urandom; new_length = $urandom; perm_mask = PERM_W'($urandom);
        chk({tag, ".req_ready_busy"}, 64'(req_ready), 64'd0);
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, ".latency"}, 64'(w), 64'd2);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check_outputs(tag, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
            check_outputs({tag, ".hold"}, e);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".req_ready_back"}, 64'(req_ready), 64'd1);
        check_outputs({tag, ".after"}, e);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        p_tag = 1'b0; p_base = '0; p_length = '0; p_perms = '0;
        new_base = '0; new_length = '0; perm_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        check_outputs("reset", '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.req_ready", 64'(req_ready), 64'd1);

        do_req("basic",   1'b1, 32'h1000, 32'h100, 3'b111, 32'h1010, 32'h20, 3'b101, 0);
        do_req("below",   1'b1, 32'h1000, 32'h100, 3'b111, 32'h0FFC, 32'h10, 3'b111, 0);
        do_req("above1",  1'b1, 32'h1000, 32'h100, 3'b111, 32'h10F0, 32'h11, 3'b111, 0);
        do_req("exact",   1'b1, 32'h1000, 32'h100, 3'b111, 32'h10F0, 32'h10, 3'b110, 0);
        do_req("zerolen", 1'b1, 32'h1000, 32'h100, 3'b011, 32'h1100, 32'h0,  3'b111, 0);
        do_req("nowrap",  1'b1, 32'hFFFFFF00, 32'h100, 3'b111, 32'hFFFFFFF0, 32'h20, 3'b111, 0);
        do_req("topmax",  1'b1, 32'hFFFFFF00, 32'h100, 3'b111, 32'hFFFFFFF0, 32'h10, 3'b010, 0);
        do_req("untag",   1'b0, 32'h1000, 32'h100, 3'b111, 32'h1010, 32'h20, 3'b111, 5);
        do_req("prio_ut", 1'b0, 32'h1000, 32'h100, 3'b111, 32'h0FF0, 32'h400, 3'b111, 0);
        do_req("prio_bl", 1'b1, 32'h1000, 32'h100, 3'b111, 32'h0FF0, 32'h400, 3'b111, 2);

        // Reset while the request sits in CHECK
        p_tag = 1'b1; p_base = 32'h1000; p_length = 32'h100; p_perms = 3'b111;
        new_base = 32'h1010; new_length = 32'h20; perm_mask = 3'b111;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_check.in_check", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_check.rsp_valid", 64'(rsp_valid), 64'd0);
        check_outputs("rst_check", '0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_check.req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("rst_check.no_rsp", 64'(rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;

        do_req("post_rst", 1'b1, 32'h2000, 32'h80, 3'b101, 32'h2000, 32'h80, 3'b111, 1);

        chk("sb.drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
